// File: rtl/led_regfile_responder.sv
// Bus-responder register file for the LED block: CTRL/pattern/DIV registers,
// sticky error status, and static / blink / rotating-blink LED drive.
module led_regfile_responder #(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [7:0]  addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rd_valid,
   output logic [15:0] led
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   localparam logic [7:0] A_CTRL   = 8'h00;
   localparam logic [7:0] A_PAT_LO = 8'h01;
   localparam logic [7:0] A_PAT_HI = 8'h02;
   localparam logic [7:0] A_DIV    = 8'h03;
   localparam logic [7:0] A_STATUS = 8'h04;
   localparam logic [7:0] A_WCNT   = 8'h05;

   logic [7:0]    ctrl_q, ctrl_d;
   logic [15:0]   pat_q, pat_d;
   logic [7:0]    div_q, div_d;
   logic          err_q, err_d;
   logic          phase_q, phase_d;
   logic [7:0]    wcnt_q, wcnt_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    tick_q, tick_d;
   logic [15:0]   led_q, led_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          rd_valid_q, rd_valid_d;

   logic       wr_map, wr_bad, rd_status, clr_cnt, run;
   logic       pre_wrap, tick_full, toggle_ev;
   logic [7:0] div_eff;

   always_comb begin
      wr_map    = wr_en && (addr <= A_DIV);
      wr_bad    = wr_en && (addr > A_DIV);
      rd_status = rd_en && (addr == A_STATUS);
      clr_cnt   = wr_en && ((addr == A_DIV) ||
                            ((addr == A_CTRL) && (wdata[1] != ctrl_q[1])));
      // Counters only run when EN was already set and is not being cleared now,
      // so the first half-period starts cleanly on the edge after EN rises.
      run       = ctrl_q[0] && !(wr_en && (addr == A_CTRL) && !wdata[0]);
      div_eff   = (div_q == 8'd0) ? 8'd1 : div_q;
      pre_wrap  = (pre_q == PRE_LAST);
      tick_full = ({1'b0, tick_q} + 9'd1) >= {1'b0, div_eff};
      toggle_ev = run && !clr_cnt && pre_wrap && tick_full;

      ctrl_d  = ctrl_q;
      div_d   = div_q;
      wcnt_d  = wcnt_q;
      pat_d   = pat_q;
      pre_d   = pre_q;
      tick_d  = tick_q;
      phase_d = phase_q;

      if (!run) begin
         pre_d   = '0;
         tick_d  = '0;
         phase_d = 1'b0;
      end else if (clr_cnt) begin
         pre_d  = '0;
         tick_d = '0;
      end else if (pre_wrap) begin
         pre_d = '0;
         if (tick_full) begin
            tick_d  = '0;
            phase_d = !phase_q;
         end else begin
            tick_d = tick_q + 8'd1;
         end
      end else begin
         pre_d = pre_q + PW'(1);
      end

      // Rotation is applied first so a same-cycle bus write overrides its byte.
      if (toggle_ev && ctrl_q[1] && ctrl_q[2] && !phase_q)
         pat_d = {pat_q[14:0], pat_q[15]};

      if (wr_map) begin
         wcnt_d = wcnt_q + 8'd1;
         case (addr)
            A_CTRL:   ctrl_d      = wdata;
            A_PAT_LO: pat_d[7:0]  = wdata;
            A_PAT_HI: pat_d[15:8] = wdata;
            default:  div_d       = wdata;
         endcase
      end

      err_d = (err_q && !rd_status) || wr_bad;

      if (!ctrl_q[0])      led_d = '0;
      else if (!ctrl_q[1]) led_d = pat_q;
      else                 led_d = phase_q ? pat_q : '0;

      rd_valid_d = rd_en;
      rdata_d    = rdata_q;
      if (rd_en) begin
         case (addr)
            A_CTRL:   rdata_d = ctrl_q;
            A_PAT_LO: rdata_d = pat_q[7:0];
            A_PAT_HI: rdata_d = pat_q[15:8];
            A_DIV:    rdata_d = div_q;
            A_STATUS: rdata_d = {6'd0, err_q, phase_q};
            A_WCNT:   rdata_d = wcnt_q;
            default:  rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= '0;
         pat_q      <= '0;
         div_q      <= 8'h01;
         err_q      <= 1'b0;
         phase_q    <= 1'b0;
         wcnt_q     <= '0;
         pre_q      <= '0;
         tick_q     <= '0;
         led_q      <= '0;
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         pat_q      <= pat_d;
         div_q      <= div_d;
         err_q      <= err_d;
         phase_q    <= phase_d;
         wcnt_q     <= wcnt_d;
         pre_q      <= pre_d;
         tick_q     <= tick_d;
         led_q      <= led_d;
         rdata_q    <= rdata_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign led      = led_q;
   assign rdata    = rdata_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_led_regfile_responder.sv
// Directed bench for led_regfile_responder with PRESCALE=4: register access,
// error status, static/blink/rotate LED drive and asynchronous reset.
module tb_led_regfile_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  addr = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata;
   logic        rd_valid;
   logic [15:0] led;

   int checks = 0;
   int failures = 0;

   led_regfile_responder #(.PRESCALE(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .led(led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic v);
      @(negedge clk);
      rd_en = 1'b1; addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      d = rdata; v = rd_valid;
   endtask

   task automatic bus_rw(input logic [7:0] a, input logic [7:0] d, output logic [7:0] r);
      @(negedge clk);
      rd_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      r = rdata;
   endtask

   logic [7:0]  r;
   logic        v;
   logic [15:0] exp_led;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_led", led, 16'h0000);
      check("rst_rdv", {15'd0, rd_valid}, 16'h0000);
      rst = 1'b0;

      // Reset values
      bus_read(8'h03, r, v);
      check("rd_div", {8'd0, r}, 16'h0001);
      check("rd_div_v", {15'd0, v}, 16'h0001);
      @(negedge clk);
      check("rdv_drop", {15'd0, rd_valid}, 16'h0000);
      check("rd_hold", {8'd0, rdata}, 16'h0001);
      bus_read(8'h07, r, v);
      check("rd_unmapped", {8'd0, r}, 16'h0000);

      // Error handling
      bus_write(8'h04, 8'h55);
      bus_read(8'h04, r, v);
      check("err_set", {8'd0, r}, 16'h0002);
      bus_read(8'h04, r, v);
      check("err_clr", {8'd0, r}, 16'h0000);
      bus_read(8'h05, r, v);
      check("wcnt_err", {8'd0, r}, 16'h0000);
      bus_write(8'h09, 8'hAA);
      bus_rw(8'h04, 8'h11, r);
      check("err_rw_pre", {8'd0, r}, 16'h0002);
      bus_read(8'h04, r, v);
      check("err_set_wins", {8'd0, r}, 16'h0002);
      bus_read(8'h04, r, v);
      check("err_clr2", {8'd0, r}, 16'h0000);

      // Static mode
      bus_write(8'h01, 8'h05);
      bus_write(8'h02, 8'hA0);
      bus_write(8'h00, 8'h01);
      check("static_lat", led, 16'h0000);
      @(negedge clk);
      check("static_led", led, 16'hA005);
      bus_read(8'h05, r, v);
      check("wcnt3", {8'd0, r}, 16'h0003);

      // Same-cycle read and write
      bus_rw(8'h01, 8'h3C, r);
      check("rw_old", {8'd0, r}, 16'h0005);
      bus_read(8'h01, r, v);
      check("rw_new", {8'd0, r}, 16'h003C);
      check("static_led2", led, 16'hA03C);

      // Blink, DIV=2: half-period 8 cycles
      bus_write(8'h00, 8'h00);
      bus_write(8'h01, 8'hFF);
      bus_write(8'h02, 8'h00);
      bus_write(8'h03, 8'h02);
      bus_write(8'h00, 8'h03);
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         exp_led = ((((i - 1) / 8) % 2) == 1) ? 16'h00FF : 16'h0000;
         check($sformatf("blink_%0d", i), led, exp_led);
      end
      bus_read(8'h04, r, v);
      check("phase_on", {8'd0, r}, 16'h0001);
      repeat (7) @(negedge clk);
      bus_read(8'h04, r, v);
      check("phase_off", {8'd0, r}, 16'h0000);

      // Rotating blink, DIV=1: half-period 4 cycles
      bus_write(8'h00, 8'h00);
      bus_write(8'h01, 8'h01);
      bus_write(8'h02, 8'h80);
      bus_write(8'h03, 8'h01);
      bus_write(8'h00, 8'h07);
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         exp_led = ((((i - 1) / 4) % 2) == 1) ? (16'h0003 << ((i - 1) / 8)) : 16'h0000;
         check($sformatf("rot_%0d", i), led, exp_led);
      end
      bus_read(8'h01, r, v);
      check("rot_pat_lo", {8'd0, r}, 16'h000C);
      repeat (4) @(negedge clk);
      check("rot_pre_rst", led, 16'h0018);

      // Reset mid-blink with a read in flight
      rst = 1'b1; rd_en = 1'b1; addr = 8'h01;
      #1;
      check("mid_rst_led", led, 16'h0000);
      check("mid_rst_rdata", {8'd0, rdata}, 16'h0000);
      @(negedge clk);
      check("mid_rst_rdv", {15'd0, rd_valid}, 16'h0000);
      rd_en = 1'b0; rst = 1'b0;
      bus_read(8'h00, r, v);
      check("post_ctrl", {8'd0, r}, 16'h0000);
      bus_read(8'h01, r, v);
      check("post_pat_lo", {8'd0, r}, 16'h0000);
      bus_read(8'h02, r, v);
      check("post_pat_hi", {8'd0, r}, 16'h0000);
      bus_read(8'h03, r, v);
      check("post_div", {8'd0, r}, 16'h0001);
      bus_read(8'h04, r, v);
      check("post_status", {8'd0, r}, 16'h0000);
      bus_read(8'h05, r, v);
      check("post_wcnt", {8'd0, r}, 16'h0000);
      check("post_led", led, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
